// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, APB address width, latched command.
// Pure declarations; no timing or flow-control behaviour of its own.
package apb_cmd_master_pkg;

  localparam int PADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic               write;
    logic [PADDR_W-1:0] addr;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_timeout.sv
// ACCESS-phase watchdog: counts enabled cycles, flags the LIMIT-th one; built only with APB_CMD_MASTER_TIMEOUT_EN.
// Latency: expired is combinational from the count; clear has priority; no backpressure.
module apb_cmd_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of ACCESS cycles already completed.
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Command/response to APB bridge; optional ACCESS timeout under APB_CMD_MASTER_TIMEOUT_EN.
// Latency: accept N, PSEL N+1, PENABLE N+2, RSP_VALID N+3 (zero-wait slave); one command in flight, CMD_READY only in IDLE.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int APB_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic [PADDR_W-1:0]   CMD_ADDR,
  input  logic [APB_WIDTH-1:0] CMD_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [APB_WIDTH-1:0] RSP_RDATA,
  output logic                 RSP_ERR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [PADDR_W-1:0]   PADDR,
  output logic [APB_WIDTH-1:0] PWDATA,
  input  logic [APB_WIDTH-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  if (!(APB_WIDTH == 8 || APB_WIDTH == 16 || APB_WIDTH == 32)) begin : g_bad_width
    $error("apb_cmd_master: APB_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t               state_q, state_d;
  cmd_t                 cmd_q, cmd_d;
  logic [APB_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timeout_hit;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .clear   (state_q != ACCESS),
    .enable  (state_q == ACCESS),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (CMD_VALID) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
      RESP:    if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state_q == IDLE);
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    RSP_VALID = (state_q == RESP);
  end

  // A real PREADY wins over a timeout landing on the same edge.
  always_comb begin
    cmd_d       = cmd_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == IDLE && CMD_VALID) begin
      cmd_d.write = CMD_WRITE;
      cmd_d.addr  = CMD_ADDR;
      pwdata_d    = CMD_WDATA;
    end
    if (state_q == ACCESS) begin
      if (PREADY) begin
        rsp_err_d   = PSLVERR;
        rsp_rdata_d = (!cmd_q.write && !PSLVERR) ? PRDATA : '0;
      end else if (timeout_hit) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cmd_q       <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PWRITE    = cmd_q.write;
  assign PADDR     = cmd_q.addr;
  assign PWDATA    = pwdata_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: hand-computed vectors for latency, waits, errors, backpressure, reset.
// The timeout scenario runs only when APB_CMD_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  logic        PCLK;
  logic        PRESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [7:0]  CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_vec;
  int n_err;

  apb_cmd_master #(
    .APB_WIDTH      (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    chk("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    tick();
    CMD_VALID = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    RSP_READY = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRESETN   = 1'b1;
    #1 PRESETN = 1'b0;
    #2;
    chk("rst_psel",      32'(PSEL),      32'd0);
    chk("rst_penable",   32'(PENABLE),   32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_err",   32'(RSP_ERR),   32'd0);
    chk("rst_paddr",     32'(PADDR),     32'd0);
    chk("rst_pwdata",    PWDATA,         32'd0);
    #19 PRESETN = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("post_rst_rdata",     RSP_RDATA,      32'd0);

    // Zero-wait write: PSEL at N+1, PENABLE at N+2, RSP_VALID at N+3.
    PREADY = 1'b1;
    PRDATA = 32'hDEAD_BEEF;
    issue(1'b1, 8'h01, 32'hA5A5_A5A5);
    chk("wr_n1_psel",    32'(PSEL),      32'd1);
    chk("wr_n1_penable", 32'(PENABLE),   32'd0);
    chk("wr_n1_pwrite",  32'(PWRITE),    32'd1);
    chk("wr_n1_paddr",   32'(PADDR),     32'h01);
    chk("wr_n1_pwdata",  PWDATA,         32'hA5A5_A5A5);
    chk("wr_n1_ready",   32'(CMD_READY), 32'd0);
    tick();
    chk("wr_n2_psel",    32'(PSEL),      32'd1);
    chk("wr_n2_penable", 32'(PENABLE),   32'd1);
    chk("wr_n2_rsp_vld", 32'(RSP_VALID), 32'd0);
    chk("wr_n2_pwdata",  PWDATA,         32'hA5A5_A5A5);
    tick();
    chk("wr_n3_rsp_vld", 32'(RSP_VALID), 32'd1);
    chk("wr_n3_psel",    32'(PSEL),      32'd0);
    chk("wr_n3_rsp_err", 32'(RSP_ERR),   32'd0);
    chk("wr_n3_rdata",   RSP_RDATA,      32'd0);
    chk("wr_hold_paddr", 32'(PADDR),     32'h01);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("wr_done_rsp_vld", 32'(RSP_VALID), 32'd0);
    chk("wr_done_ready",   32'(CMD_READY), 32'd1);

    // Read with three wait states: PENABLE stays high for four cycles.
    PREADY = 1'b0;
    PRDATA = 32'h0000_0077;
    issue(1'b0, 8'h00, 32'h1111_1111);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rdw_penable", 32'(PENABLE),   32'd1);
      chk("rdw_psel",    32'(PSEL),      32'd1);
      chk("rdw_paddr",   32'(PADDR),     32'h00);
      chk("rdw_pwrite",  32'(PWRITE),    32'd0);
      chk("rdw_rsp_vld", 32'(RSP_VALID), 32'd0);
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h0000_003C;
    chk("rdw_penable_4", 32'(PENABLE), 32'd1);
    tick();
    PREADY = 1'b0;
    chk("rdw_penable_off", 32'(PENABLE),   32'd0);
    chk("rdw_rsp_vld",     32'(RSP_VALID), 32'd1);
    chk("rdw_rdata",       RSP_RDATA,      32'h0000_003C);
    chk("rdw_err",         32'(RSP_ERR),   32'd0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;

    // Slave error on a read, then response backpressure with a pending command.
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'h1234_5678;
    issue(1'b0, 8'h22, 32'h0);
    tick();
    tick();
    PSLVERR   = 1'b0;
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 8'h33;
    CMD_WDATA = 32'h0BAD_F00D;
    chk("err_rsp_vld", 32'(RSP_VALID), 32'd1);
    chk("err_rsp_err", 32'(RSP_ERR),   32'd1);
    chk("err_rdata",   RSP_RDATA,      32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
      chk("bp_psel",      32'(PSEL),      32'd0);
      chk("bp_rsp_vld",   32'(RSP_VALID), 32'd1);
      chk("bp_rsp_err",   32'(RSP_ERR),   32'd1);
      chk("bp_rdata",     RSP_RDATA,      32'd0);
      chk("bp_paddr",     32'(PADDR),     32'h22);
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("bp_release_vld",   32'(RSP_VALID), 32'd0);
    chk("bp_release_psel",  32'(PSEL),      32'd0);
    chk("bp_release_ready", 32'(CMD_READY), 32'd1);
    tick();
    CMD_VALID = 1'b0;
    chk("bp_next_psel",   32'(PSEL),   32'd1);
    chk("bp_next_paddr",  32'(PADDR),  32'h33);
    chk("bp_next_pwdata", PWDATA,      32'h0BAD_F00D);
    tick();
    tick();
    chk("bp_next_rsp_vld", 32'(RSP_VALID), 32'd1);
    chk("bp_next_err",     32'(RSP_ERR),   32'd0);
    chk("bp_next_rdata",   RSP_RDATA,      32'd0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Stuck slave: abort after exactly four ACCESS cycles.
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 8'h44, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_penable", 32'(PENABLE),   32'd1);
      chk("to_rsp_vld", 32'(RSP_VALID), 32'd0);
      tick();
    end
    chk("to_psel",    32'(PSEL),      32'd0);
    chk("to_penable_off", 32'(PENABLE), 32'd0);
    chk("to_rsp_vld", 32'(RSP_VALID), 32'd1);
    chk("to_rsp_err", 32'(RSP_ERR),   32'd1);
    chk("to_rdata",   RSP_RDATA,      32'd0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
`endif

    // Reset asserted mid-ACCESS clears outputs without waiting for a clock edge.
    PREADY = 1'b0;
    PRDATA = 32'h0;
    issue(1'b0, 8'h55, 32'h0);
    tick();
    chk("mid_penable", 32'(PENABLE), 32'd1);
    #2 PRESETN = 1'b0;
    #1;
    chk("arst_psel",    32'(PSEL),      32'd0);
    chk("arst_penable", 32'(PENABLE),   32'd0);
    chk("arst_rsp_vld", 32'(RSP_VALID), 32'd0);
    chk("arst_paddr",   32'(PADDR),     32'd0);
    #2 PRESETN = 1'b1;
    tick();
    chk("arst_ready", 32'(CMD_READY), 32'd1);
    PREADY = 1'b1;
    issue(1'b1, 8'h7F, 32'h0000_1234);
    chk("arst_next_psel",   32'(PSEL),  32'd1);
    chk("arst_next_paddr",  32'(PADDR), 32'h7F);
    chk("arst_next_pwdata", PWDATA,     32'h0000_1234);
    tick();
    chk("arst_next_penable", 32'(PENABLE), 32'd1);
    tick();
    chk("arst_next_rsp_vld", 32'(RSP_VALID), 32'd1);
    chk("arst_next_err",     32'(RSP_ERR),   32'd0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("arst_next_done", 32'(CMD_READY), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter APB_WIDTH, default 32, meaning PWDATA/PRDATA/CMD_WDATA/RSP_RDATA width (legal 8, 16, 32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max ACCESS cycles before abort (range 1..65535; used only with APB_CMD_MASTER_TIMEOUT_EN).
REQ-003 SHALL use one clock and an asynchronous active-low reset: PCLK  in  1  sole clock, rising edge.
REQ-004 SHALL have PRESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have CMD_VALID  in  1  command request.
REQ-006 SHALL have CMD_READY  out  1  command accepted when high with CMD_VALID.
REQ-007 SHALL have CMD_WRITE  in  1  1=write, 0=read.
REQ-008 SHALL have CMD_ADDR  in  8  register address.
REQ-009 SHALL have CMD_WDATA  in  APB_WIDTH  write data.
REQ-010 SHALL have RSP_VALID  out  1  response available.
REQ-011 SHALL have RSP_READY  in  1  response consumed.
REQ-012 SHALL have RSP_RDATA  out  APB_WIDTH  read data; 0 for writes and errors.
REQ-013 SHALL have RSP_ERR  out  1  PSLVERR seen or timeout.
REQ-014 SHALL have PSEL  out  1  APB select.
REQ-015 SHALL have PENABLE  out  1  APB enable.
REQ-016 SHALL have PWRITE  out  1  APB direction.
REQ-017 SHALL have PADDR  out  8  APB address.
REQ-018 SHALL have PWDATA  out  APB_WIDTH  APB write data.
REQ-019 SHALL have PRDATA  in  APB_WIDTH  APB read data.
REQ-020 SHALL have PREADY  in  1  slave ready/wait.
REQ-021 SHALL have PSLVERR  in  1  slave error, sampled only with PREADY.

Function
REQ-022 SHALL implement FSM IDLE->SETUP->ACCESS->RESP->IDLE; CMD_READY = (state==IDLE).
REQ-023 SHALL register CMD_WRITE/CMD_ADDR/CMD_WDATA on the edge where CMD_VALID&CMD_READY, moving to SETUP.
REQ-024 SHALL in SETUP drive PSEL=1, PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-025 SHALL in ACCESS drive PSEL=1, PENABLE=1 until a rising edge with PREADY=1, then move to RESP.
REQ-026 SHALL on that edge capture RSP_RDATA=PRDATA for reads (0 for writes) and RSP_ERR=PSLVERR (RSP_RDATA=0 if PSLVERR).
REQ-027 SHALL keep PADDR/PWRITE/PWDATA stable from SETUP through transfer end, then hold last values.
REQ-028 SHALL give latency, with zero-wait slave: accept edge N, PSEL high cycle N+1, PENABLE cycle N+2, RSP_VALID cycle N+3.
REQ-029 SHALL hold RSP_VALID and response data stable in RESP until RSP_READY; return to IDLE on that edge; no new command is accepted in the same cycle.
REQ-030 SHALL never assert PENABLE without PSEL, nor start a new transfer while RSP_VALID=1.

Reset
REQ-031 SHALL on PRESETN low immediately force IDLE, PSEL/PENABLE/PWRITE/RSP_VALID/RSP_ERR=0, PADDR/PWDATA/RSP_RDATA=0, and zero the timeout counter, including mid-transfer.
REQ-032 SHALL release to IDLE with CMD_READY=1 on the first edge after PRESETN rises.

Configuration
REQ-033 SHALL, with APB_CMD_MASTER_TIMEOUT_EN defined, count ACCESS cycles; after TIMEOUT_CYCLES cycles without PREADY, deassert PSEL/PENABLE, enter RESP with RSP_ERR=1 and RSP_RDATA=0.
REQ-034 SHALL, without APB_CMD_MASTER_TIMEOUT_EN, omit the counter and wait in ACCESS indefinitely; TIMEOUT_CYCLES is ignored.

Structure
REQ-035 SHALL place the state enum (IDLE, SETUP, ACCESS, RESP) and the PADDR width constant (8) in the shared package apb_cmd_master_pkg.
REQ-036 SHALL implement the timeout counter as sub-module apb_cmd_timeout (clear, enable, expired), instantiated only under the macro.

Verification
REQ-037 SHALL cover: write 0x01 data 0xA5A5A5A5, PREADY=1 -> PSEL N+1, PENABLE N+2, PWDATA=0xA5A5A5A5, RSP_VALID N+3, RSP_ERR=0, RSP_RDATA=0.
REQ-038 SHALL cover: read 0x00, PREADY low 3 cycles, PRDATA=0x0000003C -> PENABLE high 4 cycles, RSP_RDATA=0x3C.
REQ-039 SHALL cover: read with PSLVERR=1 at PREADY -> RSP_ERR=1, RSP_RDATA=0.
REQ-040 SHALL cover: RSP_READY held low 5 cycles with CMD_VALID=1 -> CMD_READY=0, PSEL=0, response stable throughout.
REQ-041 SHALL cover: macro on, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, RSP_ERR=1.
REQ-042 SHALL cover: PRESETN low during ACCESS -> PSEL/PENABLE/RSP_VALID 0 without a clock edge; the next command completes normally.
